camera_stream_gen: RTL and testbench



---
 rtl/camera_stream_if.sv | 12 +
 rtl/camera_stream_gen.sv | 158 +++++++++++++++
 tb/tb_camera_stream_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/camera_stream_if.sv
// Parallel camera stream bundle: Bayer-style pixel data plus framing strobes
// and frame bookkeeping, as consumed by the capture path.
interface camera_stream_if;
    logic [9:0]  pix_d;
    logic        fval;
    logic        lval;
    logic        frame_done;
    logic [15:0] frame_count;

    modport master (output pix_d, fval, lval, frame_done, frame_count);
    modport slave  (input  pix_d, fval, lval, frame_done, frame_count);
endinterface

// File: rtl/camera_stream_gen.sv
// Synthetic camera pixel source: emits FVAL/LVAL framed 10-bit test patterns,
// one pixel per clock, standing in for the MIPI bridge during bring-up.
module camera_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 20,
    parameter int FV_SETUP = 16,
    parameter int FV_HOLD  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        pattern,
    camera_stream_if.master   stream
);
    localparam int LINE_LEN = H_ACTIVE + H_BLANK;
    localparam int VB_LEN   = V_FRONT * LINE_LEN;
    localparam int MAX_A    = (H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE;
    localparam int MAX_B    = (FV_SETUP > FV_HOLD) ? FV_SETUP : FV_HOLD;
    localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_D    = (MAX_C > H_BLANK) ? MAX_C : H_BLANK;
    localparam int MAX_V    = (MAX_D > VB_LEN) ? MAX_D : VB_LEN;
    localparam int CW       = $clog2(MAX_V + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LINE, HBLANK, HOLD, VBLANK} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] x_q, x_n, y_q, y_n, blank_q, blank_n;
    logic [1:0]    pat_q, pat_n;
    logic [9:0]    pix_q, pix_n, xt, yt;
    logic          fval_q, fval_n, lval_q, lval_n, done_q, done_n;
    logic [15:0]   count_q;

    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        blank_n = blank_q;
        pat_n   = pat_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_n = SETUP;
                    blank_n = CW'(FV_SETUP - 1);
                    y_n     = '0;
                    pat_n   = pattern;
                end
            end
            SETUP: begin
                if (blank_q == '0) begin
                    state_n = LINE;
                    x_n     = '0;
                end else begin
                    blank_n = blank_q - CW'(1);
                end
            end
            LINE: begin
                if (x_q == CW'(H_ACTIVE - 1)) begin
                    if (y_q < CW'(V_ACTIVE - 1)) begin
                        state_n = HBLANK;
                        blank_n = CW'(H_BLANK - 1);
                    end else begin
                        state_n = HOLD;
                        blank_n = CW'(FV_HOLD - 1);
                    end
                end else begin
                    x_n = x_q + CW'(1);
                end
            end
            HBLANK: begin
                if (blank_q == '0) begin
                    state_n = LINE;
                    x_n     = '0;
                    y_n     = y_q + CW'(1);
                end else begin
                    blank_n = blank_q - CW'(1);
                end
            end
            HOLD: begin
                if (blank_q == '0) begin
                    state_n = VBLANK;
                    blank_n = CW'(VB_LEN - 1);
                end else begin
                    blank_n = blank_q - CW'(1);
                end
            end
            VBLANK: begin
                // enable is only honoured here and in IDLE, so a frame always runs to completion
                if (blank_q == '0) begin
                    if (enable) begin
                        state_n = SETUP;
                        blank_n = CW'(FV_SETUP - 1);
                        y_n     = '0;
                        pat_n   = pattern;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    blank_n = blank_q - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered strobes line up with the FSM.
    always_comb begin
        xt     = 10'(x_n);
        yt     = 10'(y_n);
        fval_n = (state_n != IDLE) && (state_n != VBLANK);
        lval_n = (state_n == LINE);
        done_n = (state_q == HOLD) && (state_n == VBLANK);
        pix_n  = '0;
        if (lval_n) begin
            case (pat_n)
                2'd0:    pix_n = xt;
                2'd1:    pix_n = yt;
                2'd2:    pix_n = (xt[3] ^ yt[3]) ? '1 : '0;
                default: pix_n = 10'h200;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            blank_q <= '0;
            pat_q   <= '0;
            pix_q   <= '0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            blank_q <= blank_n;
            pat_q   <= pat_n;
            pix_q   <= pix_n;
            fval_q  <= fval_n;
            lval_q  <= lval_n;
            done_q  <= done_n;
            if (done_n) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign stream.pix_d       = pix_q;
    assign stream.fval        = fval_q;
    assign stream.lval        = lval_q;
    assign stream.frame_done  = done_q;
    assign stream.frame_count = count_q;
endmodule

// File: tb/tb_camera_stream_gen.sv
// Bench for camera_stream_gen: a small-parameter and a default-parameter instance
// are compared every cycle against a frame-timing model built from the frame period.
module tb_camera_stream_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s, en_s, rst_d, en_d;
    logic [1:0] pat_s, pat_d;

    camera_stream_if s_if ();
    camera_stream_if d_if ();

    camera_stream_gen #(
        .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .V_FRONT(2), .FV_SETUP(3), .FV_HOLD(2)
    ) dut_s (
        .clk(clk), .reset(rst_s), .enable(en_s), .pattern(pat_s), .stream(s_if.master)
    );

    camera_stream_gen dut_d (
        .clk(clk), .reset(rst_d), .enable(en_d), .pattern(pat_d), .stream(d_if.master)
    );

    int checks = 0;
    int errors = 0;

    int ha[2] = '{8, 640};
    int hb[2] = '{4, 160};
    int va[2] = '{4, 480};
    int vf[2] = '{2, 20};
    int fs[2] = '{3, 16};
    int fh[2] = '{2, 16};

    bit          m_run[2];
    int          m_p[2];
    logic [1:0]  m_pat[2];
    logic [15:0] m_cnt[2];
    logic        e_fval[2], e_lval[2], e_done[2];
    logic [9:0]  e_pix[2];
    int          cb_seen = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fv_len(input int i);
        return fs[i] + va[i] * (ha[i] + hb[i]) - hb[i] + fh[i];
    endfunction

    // Model state is just "running" plus the cycle index within the frame period.
    task automatic model_tick(input int i, input logic rst, input logic en, input logic [1:0] pt);
        int per;
        per = fv_len(i) + vf[i] * (ha[i] + hb[i]);
        if (rst) begin
            m_run[i] = 1'b0;
            m_p[i]   = 0;
            m_cnt[i] = 16'h0;
        end else if (!m_run[i]) begin
            if (en) begin
                m_run[i] = 1'b1;
                m_p[i]   = 0;
                m_pat[i] = pt;
            end
        end else begin
            m_p[i]++;
            if (m_p[i] == per) begin
                if (en) begin
                    m_p[i]   = 0;
                    m_pat[i] = pt;
                end else begin
                    m_run[i] = 1'b0;
                end
            end
        end
        if (m_run[i] && m_p[i] == fv_len(i)) m_cnt[i] = m_cnt[i] + 16'd1;
    endtask

    task automatic model_eval(input int i);
        int l, q, x, y;
        l = ha[i] + hb[i];
        q = m_p[i] - fs[i];
        e_fval[i] = m_run[i] && (m_p[i] < fv_len(i));
        e_done[i] = m_run[i] && (m_p[i] == fv_len(i));
        e_lval[i] = m_run[i] && (q >= 0) && (q < va[i] * l - hb[i]) && ((q % l) < ha[i]);
        e_pix[i]  = 10'h0;
        if (e_lval[i]) begin
            x = q % l;
            y = q / l;
            case (m_pat[i])
                2'd0:    e_pix[i] = 10'(x % 1024);
                2'd1:    e_pix[i] = 10'(y % 1024);
                2'd2:    e_pix[i] = (((x / 8) % 2) != ((y / 8) % 2)) ? 10'h3FF : 10'h000;
                default: e_pix[i] = 10'h200;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick(0, rst_s, en_s, pat_s);
        model_tick(1, rst_d, en_d, pat_d);
        #1;
        model_eval(0);
        model_eval(1);
        check("s_fval",  16'(s_if.fval),        16'(e_fval[0]));
        check("s_lval",  16'(s_if.lval),        16'(e_lval[0]));
        check("s_pix",   16'(s_if.pix_d),       16'(e_pix[0]));
        check("s_done",  16'(s_if.frame_done),  16'(e_done[0]));
        check("s_count", s_if.frame_count,      m_cnt[0]);
        check("s_lval_without_fval", 16'(s_if.lval & ~s_if.fval), 16'h0);
        check("d_fval",  16'(d_if.fval),        16'(e_fval[1]));
        check("d_lval",  16'(d_if.lval),        16'(e_lval[1]));
        check("d_pix",   16'(d_if.pix_d),       16'(e_pix[1]));
        check("d_done",  16'(d_if.frame_done),  16'(e_done[1]));
        check("d_count", d_if.frame_count,      m_cnt[1]);
        if (m_run[1]) begin
            if (m_p[1] == 16 + 5)           begin check("cb_l0_x5",  16'(d_if.pix_d), 16'h000); cb_seen++; end
            if (m_p[1] == 16 + 12)          begin check("cb_l0_x12", 16'(d_if.pix_d), 16'h3FF); cb_seen++; end
            if (m_p[1] == 16 + 8 * 800 + 3) begin check("cb_l8_x3",  16'(d_if.pix_d), 16'h3FF); cb_seen++; end
            if (m_p[1] == 16 + 8 * 800 + 12) begin check("cb_l8_x12", 16'(d_if.pix_d), 16'h000); cb_seen++; end
        end
    endtask

    initial begin
        int hi, dn, k;
        logic [15:0] exp_cnt;

        rst_s = 1'b1; rst_d = 1'b1; en_s = 1'b0; en_d = 1'b0; pat_s = 2'd0; pat_d = 2'd2;
        step();
        step();
        check("rst_fval",  16'(s_if.fval),  16'h0);
        check("rst_pix",   16'(s_if.pix_d), 16'h0);
        check("rst_count", s_if.frame_count, 16'h0);

        // Two back-to-back horizontal-ramp frames.
        rst_s = 1'b0; rst_d = 1'b0; en_s = 1'b1; en_d = 1'b1;
        hi = 0; dn = 0;
        for (int n = 0; n < 146; n++) begin
            step();
            if (s_if.fval) hi++;
            if (s_if.frame_done) dn++;
            if (m_p[0] == 3 + 12 + 5) check("hramp_l1_x5", 16'(s_if.pix_d), 16'd5);
            if (m_p[0] == 3 + 8)      check("hblank_pix0", 16'(s_if.pix_d), 16'd0);
        end
        check("fval_high_2frames", 16'(hi), 16'd98);
        check("done_pulses_2frames", 16'(dn), 16'd2);
        check("count_after_2", s_if.frame_count, 16'd2);

        // Vertical ramp frame.
        pat_s = 2'd1;
        for (int n = 0; n < 73; n++) begin
            step();
            if (m_p[0] == 3 + 2 * 12 + 4) check("vramp_l2", 16'(s_if.pix_d), 16'd2);
            if (m_p[0] == 3 + 3 * 12 + 7) check("vramp_l3", 16'(s_if.pix_d), 16'd3);
        end

        // Randomized inputs on the small instance while the default one reaches line 8.
        for (int n = 0; n < 7000 && !(m_run[1] && m_p[1] > 16 + 8 * 800 + 16); n++) begin
            pat_s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) en_s = ~en_s;
            step();
        end
        check("checker_points_seen", 16'(cb_seen), 16'd4);
        rst_d = 1'b1;

        // Enable dropped mid-line 2: the frame completes, then the source idles.
        en_s = 1'b1;
        for (k = 0; k < 200 && !(m_run[0] && m_p[0] == 0); k++) step();
        check("wait_frame_start", 16'(k < 200), 16'h1);
        for (k = 0; k < 100 && m_p[0] != 3 + 2 * 12 + 4; k++) step();
        check("wait_mid_line2", 16'(k < 100), 16'h1);
        en_s = 1'b0;
        exp_cnt = m_cnt[0] + 16'd1;
        dn = 0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (s_if.frame_done) dn++;
        end
        check("drop_done_once", 16'(dn), 16'd1);
        check("drop_count", s_if.frame_count, exp_cnt);
        check("drop_idle_fval", 16'(s_if.fval), 16'h0);
        pat_s = 2'd1;
        en_s = 1'b1;
        step();
        check("reenable_fval", 16'(s_if.fval), 16'h1);

        // Pattern switched 1 -> 3 mid-frame takes effect next frame.
        for (k = 0; k < 100 && m_p[0] != 3 + 12 + 2; k++) step();
        check("wait_line1", 16'(k < 100), 16'h1);
        check("sw_vramp_l1", 16'(s_if.pix_d), 16'd1);
        pat_s = 2'd3;
        for (k = 0; k < 100 && m_p[0] != 3 + 3 * 12 + 5; k++) step();
        check("sw_vramp_l3", 16'(s_if.pix_d), 16'd3);
        for (k = 0; k < 150 && m_p[0] != 3 + 4; k++) step();
        check("wait_next_frame", 16'(k < 150), 16'h1);
        check("sw_flat", 16'(s_if.pix_d), 16'h200);

        // Reset while lval is high.
        for (k = 0; k < 100 && !s_if.lval; k++) step();
        check("wait_lval", 16'(k < 100), 16'h1);
        rst_s = 1'b1;
        step();
        check("midrst_fval",  16'(s_if.fval),  16'h0);
        check("midrst_lval",  16'(s_if.lval),  16'h0);
        check("midrst_pix",   16'(s_if.pix_d), 16'h0);
        check("midrst_count", s_if.frame_count, 16'h0);
        rst_s = 1'b0;
        step();
        check("post_rst_fval", 16'(s_if.fval), 16'h1);

        // Frame counter wrap from 0xFFFF.
        for (k = 0; k < 100 && m_p[0] != 10; k++) step();
        force dut_s.count_q = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        #1;
        release dut_s.count_q;
        for (k = 0; k < 100 && !s_if.frame_done; k++) step();
        check("wait_wrap_done", 16'(k < 100), 16'h1);
        check("wrap_count", s_if.frame_count, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
